// File: rtl/armleo_mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state, port count and the
// round-robin pick helper used by armleo_mem_arbiter2.
package armleo_mem_arb_pkg;

   localparam int unsigned PORT_COUNT = 2;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_t;

   // One-hot grant; on a tie the port that did not win last time is chosen.
   function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_port);
      logic [1:0] grant;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_port ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      return grant;
   endfunction

endpackage

// File: rtl/armleo_mem_1rwm.sv
// Single-port read-first RAM with per-lane write enables and a registered
// read port; readdata updates only on cycles with read_i asserted.
module armleo_mem_1rwm #(
   parameter int DEPTH_LOG2 = 7,
   parameter int WIDTH      = 32,
   parameter int GRANULITY  = 8
) (
   input  logic                         clk,
   input  logic [DEPTH_LOG2-1:0]        address_i,
   input  logic                         read_i,
   input  logic                         write_i,
   input  logic [(WIDTH/GRANULITY)-1:0] writeenable_i,
   input  logic [WIDTH-1:0]             writedata_i,
   output logic [WIDTH-1:0]             readdata_o
);

   localparam int LANES = WIDTH / GRANULITY;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] readdata_q;

   // Read samples the old word, so a simultaneous write returns pre-write data.
   always_ff @(posedge clk) begin
      if (read_i) begin
         readdata_q <= mem_q[address_i];
      end
      if (write_i) begin
         for (int l = 0; l < LANES; l++) begin
            if (writeenable_i[l]) begin
               mem_q[address_i][l*GRANULITY +: GRANULITY] <= writedata_i[l*GRANULITY +: GRANULITY];
            end
         end
      end
   end

   assign readdata_o = readdata_q;

endmodule

// File: rtl/armleo_mem_arbiter2.sv
// Two-port round-robin arbiter in front of one armleo_mem_1rwm.
// Define ARMLEO_MEM_ARB_INIT_EN to zero-fill the memory after every reset.
module armleo_mem_arbiter2
   import armleo_mem_arb_pkg::*;
#(
   parameter int DEPTH_LOG2 = 7,
   parameter int WIDTH      = 32,
   parameter int GRANULITY  = 8
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [PORT_COUNT-1:0]                   req_valid,
   output logic [PORT_COUNT-1:0]                   req_ready,
   input  logic [PORT_COUNT-1:0]                   req_write,
   input  logic [PORT_COUNT*DEPTH_LOG2-1:0]        req_address,
   input  logic [PORT_COUNT*(WIDTH/GRANULITY)-1:0] req_writeenable,
   input  logic [PORT_COUNT*WIDTH-1:0]             req_writedata,
   output logic [PORT_COUNT-1:0]                   resp_valid,
   output logic [PORT_COUNT*WIDTH-1:0]             resp_readdata,
   output logic                                    init_done
);

   localparam int LANES = WIDTH / GRANULITY;

`ifdef ARMLEO_MEM_ARB_INIT_EN
   localparam arb_state_t RESET_STATE = INIT;
`else
   localparam arb_state_t RESET_STATE = RUN;
`endif

   arb_state_t              state_q;
   logic [DEPTH_LOG2-1:0]   init_addr_q;
   logic                    last_q;
   logic [PORT_COUNT-1:0]   resp_valid_q;
   logic [WIDTH-1:0]        held_q [PORT_COUNT];

   logic [PORT_COUNT-1:0]   grant_s;
   logic                    sel_s;
   logic [DEPTH_LOG2-1:0]   mem_address_s;
   logic                    mem_read_s;
   logic                    mem_write_s;
   logic [LANES-1:0]        mem_writeenable_s;
   logic [WIDTH-1:0]        mem_writedata_s;
   logic [WIDTH-1:0]        mem_readdata_s;

   // Grant is combinational; nothing is granted in reset or while filling.
   always_comb begin
      grant_s = 2'b00;
      if (rst_n && (state_q == RUN)) begin
         grant_s = rr_pick(req_valid, last_q);
      end else begin
         grant_s = 2'b00;
      end
   end

   assign sel_s     = grant_s[1];
   assign req_ready = grant_s;

   // Storage port mux: zero-fill walker in INIT, granted port in RUN.
   always_comb begin
      mem_address_s     = '0;
      mem_read_s        = 1'b0;
      mem_write_s       = 1'b0;
      mem_writeenable_s = '0;
      mem_writedata_s   = '0;
      if (rst_n && (state_q == INIT)) begin
         mem_address_s     = init_addr_q;
         mem_write_s       = 1'b1;
         mem_writeenable_s = '1;
      end else if (grant_s != 2'b00) begin
         mem_read_s        = 1'b1;
         mem_write_s       = req_write[sel_s];
         mem_address_s     = sel_s ? req_address[DEPTH_LOG2 +: DEPTH_LOG2] : req_address[0 +: DEPTH_LOG2];
         mem_writeenable_s = sel_s ? req_writeenable[LANES +: LANES] : req_writeenable[0 +: LANES];
         mem_writedata_s   = sel_s ? req_writedata[WIDTH +: WIDTH] : req_writedata[0 +: WIDTH];
      end else begin
         mem_read_s        = 1'b0;
         mem_write_s       = 1'b0;
      end
   end

   // FSM, round-robin pointer, response pulse and per-port held data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RESET_STATE;
         init_addr_q  <= '0;
         last_q       <= 1'b1;
         resp_valid_q <= '0;
         for (int p = 0; p < PORT_COUNT; p++) begin
            held_q[p] <= '0;
         end
      end else begin
         case (state_q)
            INIT: begin
               init_addr_q <= init_addr_q + DEPTH_LOG2'(1);
               if (init_addr_q == '1) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= RESET_STATE;
            end
         endcase
         resp_valid_q <= grant_s;
         if (grant_s != 2'b00) begin
            last_q <= sel_s;
         end
         for (int p = 0; p < PORT_COUNT; p++) begin
            if (resp_valid_q[p]) begin
               held_q[p] <= mem_readdata_s;
            end
         end
      end
   end

   // Outputs are forced low during reset, which also drops an in-flight response.
   always_comb begin
      resp_valid    = resp_valid_q & {PORT_COUNT{rst_n}};
      init_done     = rst_n && (state_q == RUN);
      resp_readdata = '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         if (!rst_n) begin
            resp_readdata[p*WIDTH +: WIDTH] = '0;
         end else if (resp_valid_q[p]) begin
            resp_readdata[p*WIDTH +: WIDTH] = mem_readdata_s;
         end else begin
            resp_readdata[p*WIDTH +: WIDTH] = held_q[p];
         end
      end
   end

   armleo_mem_1rwm #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WIDTH),
      .GRANULITY  (GRANULITY)
   ) u_storage (
      .clk           (clk),
      .address_i     (mem_address_s),
      .read_i        (mem_read_s),
      .write_i       (mem_write_s),
      .writeenable_i (mem_writeenable_s),
      .writedata_i   (mem_writedata_s),
      .readdata_o    (mem_readdata_s)
   );

endmodule
